// File: rtl/poly_eval_arbiter.sv
// -----------------------------------------------------------------------------
// poly_eval_arbiter
//
// Shares one polynomial-evaluation datapath (registers A, B, C, X, R plus a
// single add/multiply ALU) between two requesters. A job evaluates
// R = A*X^2 + B*X + C (mod 2^DATA_W). The arbiter picks a winner round-robin,
// latches its operands, sequences the datapath through a fixed load/compute
// schedule and returns the result with a one-cycle done pulse.
//
// Ports
//   clk            rising-edge clock
//   resetn         asynchronous active-low reset
//   req[1:0]       per-port request level
//   op_{a,b,c,x}0  port 0 operands (stable while req[0] is high, until grant)
//   op_{a,b,c,x}1  port 1 operands (stable while req[1] is high, until grant)
//   grant[1:0]     one-hot pulse: that port's operands have been captured
//   done[1:0]      one-hot pulse: that port's result is on dp_result
//   result         result of the most recent job (updated leaving DONE)
//   busy           high in every state except IDLE
//   dp_data_in     operand driven onto the datapath load bus
//   dp_ld_*        datapath register load enables
//   dp_ld_alu_out  A/B load source: 1 = ALU output, 0 = dp_data_in
//   dp_alu_sel_a/b ALU operand select: 0=A, 1=B, 2=C, 3=X
//   dp_alu_op      0 = add, 1 = multiply
//   dp_result      datapath R register
// -----------------------------------------------------------------------------
module poly_eval_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [1:0]        req,
  input  logic [DATA_W-1:0] op_a0,
  input  logic [DATA_W-1:0] op_b0,
  input  logic [DATA_W-1:0] op_c0,
  input  logic [DATA_W-1:0] op_x0,
  input  logic [DATA_W-1:0] op_a1,
  input  logic [DATA_W-1:0] op_b1,
  input  logic [DATA_W-1:0] op_c1,
  input  logic [DATA_W-1:0] op_x1,
  output logic [1:0]        grant,
  output logic [1:0]        done,
  output logic [DATA_W-1:0] result,
  output logic              busy,
  output logic [DATA_W-1:0] dp_data_in,
  output logic              dp_ld_a,
  output logic              dp_ld_b,
  output logic              dp_ld_c,
  output logic              dp_ld_x,
  output logic              dp_ld_r,
  output logic              dp_ld_alu_out,
  output logic [1:0]        dp_alu_sel_a,
  output logic [1:0]        dp_alu_sel_b,
  output logic              dp_alu_op,
  input  logic [DATA_W-1:0] dp_result
);

  typedef enum logic [3:0] {
    IDLE, LOAD_A, LOAD_B, LOAD_C, LOAD_X, C0, C1, C2, C3, C4, DONE
  } state_t;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;
  localparam logic [1:0] SEL_X = 2'd3;
  localparam logic       OP_ADD = 1'b0;
  localparam logic       OP_MUL = 1'b1;

  state_t            state, state_n;
  logic              owner;
  logic              last_served;
  logic              winner;
  logic              accept;
  logic [DATA_W-1:0] a_lat, b_lat, c_lat, x_lat;

  // Round-robin pick: a lone requester always wins; on a tie the port that
  // was not served last goes next, which gives strict alternation.
  always_comb begin
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_served;
      default: winner = 1'b0;
    endcase
  end

  assign accept = (state == IDLE) && (|req);

  // Next-state logic: everything but IDLE advances unconditionally.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (|req) state_n = LOAD_A;
      LOAD_A:  state_n = LOAD_B;
      LOAD_B:  state_n = LOAD_C;
      LOAD_C:  state_n = LOAD_X;
      LOAD_X:  state_n = C0;
      C0:      state_n = C1;
      C1:      state_n = C2;
      C2:      state_n = C3;
      C3:      state_n = C4;
      C4:      state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_served <= 1'b1;
      result      <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        owner       <= winner;
        last_served <= winner;
      end
      if (state == DONE) result <= dp_result;
    end
  end

  // NOTE: the operand latches carry no reset; they are only read in the LOAD
  // states, which are always preceded by a capture, so a reset would only
  // add fan-out to the reset tree.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_lat <= winner ? op_a1 : op_a0;
      b_lat <= winner ? op_b1 : op_b0;
      c_lat <= winner ? op_c1 : op_c0;
      x_lat <= winner ? op_x1 : op_x0;
    end
  end

  // Moore output decode. C0/C1 square X into A, C2 forms B*X, C3 sums the
  // two products into A, and C4 adds C while loading R.
  // NOTE: every output gets a default before the case so no path through the
  // block leaves a value unassigned, which would infer a latch.
  always_comb begin
    grant         = '0;
    done          = '0;
    busy          = (state != IDLE);
    dp_data_in    = '0;
    dp_ld_a       = 1'b0;
    dp_ld_b       = 1'b0;
    dp_ld_c       = 1'b0;
    dp_ld_x       = 1'b0;
    dp_ld_r       = 1'b0;
    dp_ld_alu_out = 1'b0;
    dp_alu_sel_a  = SEL_A;
    dp_alu_sel_b  = SEL_A;
    dp_alu_op     = OP_ADD;
    case (state)
      LOAD_A: begin
        grant[owner] = 1'b1;
        dp_data_in   = a_lat;
        dp_ld_a      = 1'b1;
      end
      LOAD_B: begin
        dp_data_in = b_lat;
        dp_ld_b    = 1'b1;
      end
      LOAD_C: begin
        dp_data_in = c_lat;
        dp_ld_c    = 1'b1;
      end
      LOAD_X: begin
        dp_data_in = x_lat;
        dp_ld_x    = 1'b1;
      end
      C0, C1: begin
        dp_ld_a       = 1'b1;
        dp_ld_alu_out = 1'b1;
        dp_alu_sel_a  = SEL_A;
        dp_alu_sel_b  = SEL_X;
        dp_alu_op     = OP_MUL;
      end
      C2: begin
        dp_ld_b       = 1'b1;
        dp_ld_alu_out = 1'b1;
        dp_alu_sel_a  = SEL_B;
        dp_alu_sel_b  = SEL_X;
        dp_alu_op     = OP_MUL;
      end
      C3: begin
        dp_ld_a       = 1'b1;
        dp_ld_alu_out = 1'b1;
        dp_alu_sel_a  = SEL_A;
        dp_alu_sel_b  = SEL_B;
        dp_alu_op     = OP_ADD;
      end
      C4: begin
        dp_ld_r      = 1'b1;
        dp_alu_sel_a = SEL_A;
        dp_alu_sel_b = SEL_C;
        dp_alu_op    = OP_ADD;
      end
      DONE: begin
        done[owner] = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_poly_eval_arbiter.sv
// -----------------------------------------------------------------------------
// tb_poly_eval_arbiter
//
// Self-checking bench for poly_eval_arbiter. A small behavioural datapath
// (registers A, B, C, X, R and an add/multiply ALU) answers the arbiter's
// control signals; expected results come from the polynomial evaluated with
// plain integer arithmetic, and expected grant order from the round-robin rule.
// -----------------------------------------------------------------------------
module tb_poly_eval_arbiter;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [1:0]   req = '0;
  logic [W-1:0] op_a0 = '0, op_b0 = '0, op_c0 = '0, op_x0 = '0;
  logic [W-1:0] op_a1 = '0, op_b1 = '0, op_c1 = '0, op_x1 = '0;
  logic [1:0]   grant, done;
  logic [W-1:0] result, dp_data_in, dp_result;
  logic         busy, dp_ld_a, dp_ld_b, dp_ld_c, dp_ld_x, dp_ld_r;
  logic         dp_ld_alu_out, dp_alu_op;
  logic [1:0]   dp_alu_sel_a, dp_alu_sel_b;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference state kept by the bench
  int           model_last = 1;
  logic [W-1:0] model_result = '0;
  int           last_grant_cyc = 0;

  poly_eval_arbiter #(.DATA_W(W)) dut (
    .clk(clk), .resetn(resetn), .req(req),
    .op_a0(op_a0), .op_b0(op_b0), .op_c0(op_c0), .op_x0(op_x0),
    .op_a1(op_a1), .op_b1(op_b1), .op_c1(op_c1), .op_x1(op_x1),
    .grant(grant), .done(done), .result(result), .busy(busy),
    .dp_data_in(dp_data_in), .dp_ld_a(dp_ld_a), .dp_ld_b(dp_ld_b),
    .dp_ld_c(dp_ld_c), .dp_ld_x(dp_ld_x), .dp_ld_r(dp_ld_r),
    .dp_ld_alu_out(dp_ld_alu_out), .dp_alu_sel_a(dp_alu_sel_a),
    .dp_alu_sel_b(dp_alu_sel_b), .dp_alu_op(dp_alu_op), .dp_result(dp_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural datapath
  logic [W-1:0] m_a, m_b, m_c, m_x, m_r, alu_l, alu_r, alu_y;
  always_comb begin
    case (dp_alu_sel_a)
      2'd0: alu_l = m_a;
      2'd1: alu_l = m_b;
      2'd2: alu_l = m_c;
      default: alu_l = m_x;
    endcase
    case (dp_alu_sel_b)
      2'd0: alu_r = m_a;
      2'd1: alu_r = m_b;
      2'd2: alu_r = m_c;
      default: alu_r = m_x;
    endcase
    alu_y = dp_alu_op ? W'(alu_l * alu_r) : W'(alu_l + alu_r);
  end
  always @(posedge clk) begin
    if (dp_ld_a) m_a <= dp_ld_alu_out ? alu_y : dp_data_in;
    if (dp_ld_b) m_b <= dp_ld_alu_out ? alu_y : dp_data_in;
    if (dp_ld_c) m_c <= dp_data_in;
    if (dp_ld_x) m_x <= dp_data_in;
    if (dp_ld_r) m_r <= alu_y;
  end
  assign dp_result = m_r;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] poly(input int a, input int b, input int c, input int x);
    int v;
    v = a * x * x + b * x + c;
    return W'(v & 255);
  endfunction

  function automatic logic [31:0] outs_packed();
    return {grant, done, busy, result, dp_data_in, dp_ld_a, dp_ld_b, dp_ld_c,
            dp_ld_x, dp_ld_r, dp_ld_alu_out, dp_alu_sel_a, dp_alu_sel_b, dp_alu_op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int port, input int a, input int b, input int c, input int x);
    if (port == 0) begin
      op_a0 = W'(a); op_b0 = W'(b); op_c0 = W'(c); op_x0 = W'(x);
    end else begin
      op_a1 = W'(a); op_b1 = W'(b); op_c1 = W'(c); op_x1 = W'(x);
    end
  endtask

  // Runs one job from the IDLE cycle: waits (bounded) for the grant, checks
  // the grant, busy window, done pulse and result timing. With drop_req the
  // port releases req after its grant and scrambles its operands.
  task automatic serve(input int exp_port, input bit drop_req,
                       input logic [W-1:0] exp_res, input string tag);
    logic [1:0]   exp_oh;
    logic [W-1:0] prev_res;
    int           waited;
    exp_oh   = (exp_port == 0) ? 2'b01 : 2'b10;
    prev_res = model_result;
    waited   = 0;
    tick();
    while (grant == 2'b00 && waited < 30) begin
      tick();
      waited++;
    end
    n_cmp++;
    if (grant !== exp_oh) begin
      n_err++;
      $display("FAIL %s grant: got %b want %b (cycle %0d)", tag, grant, exp_oh, cyc);
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s busy@grant: got %b want 1", tag, busy);
    end
    last_grant_cyc = cyc;
    model_last     = exp_port;
    if (drop_req) begin
      req[exp_port] = 1'b0;
      set_ops(exp_port, $urandom_range(255), $urandom_range(255),
              $urandom_range(255), $urandom_range(255));
    end
    for (int k = 2; k <= 10; k++) begin
      tick();
      n_cmp++;
      if (busy !== 1'b1 || grant !== 2'b00) begin
        n_err++;
        $display("FAIL %s busy/grant at E+%0d: got busy=%b grant=%b want busy=1 grant=00",
                 tag, k, busy, grant);
      end
      if (k < 10) begin
        n_cmp++;
        if (done !== 2'b00) begin
          n_err++;
          $display("FAIL %s early done at E+%0d: got %b want 00", tag, k, done);
        end
      end else begin
        n_cmp++;
        if (done !== exp_oh) begin
          n_err++;
          $display("FAIL %s done: got %b want %b", tag, done, exp_oh);
        end
        n_cmp++;
        if (dp_result !== exp_res) begin
          n_err++;
          $display("FAIL %s dp_result: got %0d want %0d", tag, dp_result, exp_res);
        end
        n_cmp++;
        if (result !== prev_res) begin
          n_err++;
          $display("FAIL %s result during done: got %0d want previous %0d", tag, result, prev_res);
        end
      end
    end
    tick();
    n_cmp++;
    if (result !== exp_res || busy !== 1'b0 || done !== 2'b00) begin
      n_err++;
      $display("FAIL %s after done: got result=%0d busy=%b done=%b want result=%0d busy=0 done=00",
               tag, result, busy, done, exp_res);
    end
    model_result = exp_res;
  endtask

  task automatic test_reset();
    tick();
    n_cmp++;
    if (outs_packed() !== 32'h0) begin
      n_err++;
      $display("FAIL reset_por outputs: got %h want 0", outs_packed());
    end
    resetn = 1'b1;
    model_last = 1;
    model_result = '0;
    req = 2'b01;
    set_ops(0, $urandom_range(255), $urandom_range(255), $urandom_range(255), $urandom_range(255));
    repeat (3) tick();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_prejob busy: got %b want 1", busy);
    end
    #3 resetn = 1'b0;
    #1;
    n_cmp++;
    if (outs_packed() !== 32'h0) begin
      n_err++;
      $display("FAIL reset_async outputs: got %h want 0", outs_packed());
    end
    req = 2'b00;
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || grant !== 2'b00 || done !== 2'b00) begin
      n_err++;
      $display("FAIL reset_release idle: got busy=%b grant=%b done=%b want 0/00/00", busy, grant, done);
    end
  endtask

  task automatic test_simultaneous();
    int g0;
    set_ops(0, 1, 1, 1, 1);
    set_ops(1, 0, 0, 7, 3);
    req = 2'b11;
    serve(0, 1'b1, poly(1, 1, 1, 1), "simul_p0");
    g0 = last_grant_cyc;
    serve(1, 1'b1, poly(0, 0, 7, 3), "simul_p1");
    n_cmp++;
    if (last_grant_cyc - g0 != 11) begin
      n_err++;
      $display("FAIL simul grant spacing: got %0d want 11", last_grant_cyc - g0);
    end
  endtask

  task automatic test_single();
    set_ops(0, 2, 3, 4, 5);
    req = 2'b01;
    serve(0, 1'b1, poly(2, 3, 4, 5), "single_p0");
  endtask

  task automatic test_overflow();
    set_ops(1, 10, 0, 0, 10);
    req = 2'b10;
    serve(1, 1'b1, poly(10, 0, 0, 10), "overflow_p1");
  endtask

  task automatic test_random();
    int p, a, b, c, x;
    for (int j = 0; j < 6; j++) begin
      p = $urandom_range(1);
      a = $urandom_range(255); b = $urandom_range(255);
      c = $urandom_range(255); x = $urandom_range(255);
      set_ops(p, a, b, c, x);
      req[p] = 1'b1;
      serve(p, 1'b1, poly(a, b, c, x), "random");
    end
  endtask

  task automatic test_fairness();
    int a0, b0, c0, x0, a1, b1, c1, x1, exp_p;
    a0 = $urandom_range(255); b0 = $urandom_range(255);
    c0 = $urandom_range(255); x0 = $urandom_range(255);
    a1 = $urandom_range(255); b1 = $urandom_range(255);
    c1 = $urandom_range(255); x1 = $urandom_range(255);
    set_ops(0, a0, b0, c0, x0);
    set_ops(1, a1, b1, c1, x1);
    req = 2'b11;
    for (int j = 0; j < 5; j++) begin
      exp_p = 1 - model_last;
      if (exp_p == 0) serve(0, 1'b0, poly(a0, b0, c0, x0), "fair");
      else            serve(1, 1'b0, poly(a1, b1, c1, x1), "fair");
    end
    req = 2'b00;
  endtask

  task automatic test_reset_mid_job();
    req = 2'b10;
    set_ops(1, $urandom_range(255), $urandom_range(255), $urandom_range(255), $urandom_range(255));
    tick();
    n_cmp++;
    if (grant !== 2'b10) begin
      n_err++;
      $display("FAIL midreset grant: got %b want 10", grant);
    end
    req = 2'b00;
    repeat (6) tick();  // now in C2 (E+7)
    #2 resetn = 1'b0;
    #1;
    n_cmp++;
    if (outs_packed() !== 32'h0) begin
      n_err++;
      $display("FAIL midreset outputs: got %h want 0", outs_packed());
    end
    model_last = 1;
    model_result = '0;
    repeat (3) tick();
    resetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++;
      if (done !== 2'b00 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL midreset aborted job: got done=%b busy=%b want 00/0", done, busy);
      end
    end
    set_ops(1, 0, 2, 1, 3);
    req = 2'b10;
    serve(1, 1'b1, poly(0, 2, 1, 3), "midreset_job");
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_single();
    test_overflow();
    test_random();
    test_fairness();
    test_reset_mid_job();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
